// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system-bus controller.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_e;

    // Slot 0 = data memory at nibble 0, then accel/GPIO/timer at 8/9/A.
    localparam logic [15:0] SLOT_BASE_DEF = {4'hA, 4'h9, 4'h8, 4'h0};

    localparam int unsigned SLOT_MEM  = 0;
    localparam int unsigned SLOT_FACT = 1;
    localparam int unsigned SLOT_GPIO = 2;
    localparam int unsigned SLOT_TMR  = 3;

endpackage

// File: rtl/sys_bus_dec.sv
// Address-nibble decoder: matches against the slot base table, lowest index wins.
module sys_bus_dec
    import sys_bus_pkg::*;
#(
    parameter int unsigned       NSLV      = 4,
    parameter int unsigned       SW        = 2,
    parameter logic [NSLV*4-1:0] SLOT_BASE = SLOT_BASE_DEF
) (
    input  logic [3:0]    nib,
    output logic          hit_c,
    output logic [SW-1:0] slot_c
);

    // Scan from the top down so the lowest matching slot is written last.
    always_comb begin
        hit_c  = 1'b0;
        slot_c = '0;
        for (int k = int'(NSLV) - 1; k >= 0; k--) begin
            if (nib == SLOT_BASE[4*k +: 4]) begin
                hit_c  = 1'b1;
                slot_c = SW'(k);
            end
        end
    end

endmodule

// File: rtl/sys_bus_ctrl.sv
// CPU-to-slave bus controller: decode, one-hot select, ready wait with timeout,
// registered read data and sticky error address.
module sys_bus_ctrl
    import sys_bus_pkg::*;
#(
    parameter int unsigned       NSLV      = 4,
    parameter int unsigned       AW        = 12,
    parameter int unsigned       DW        = 32,
    parameter logic [NSLV*4-1:0] SLOT_BASE = SLOT_BASE_DEF,
    parameter int unsigned       TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [AW-3:0]      a,
    input  logic               we,
    input  logic [DW-1:0]      wd,
    output logic [DW-1:0]      rdata,
    output logic               ready,
    output logic               err,
    output logic [AW-3:0]      err_addr,
    output logic [NSLV-1:0]    sel_s,
    output logic [NSLV-1:0]    we_s,
    output logic [AW-3:0]      addr_s,
    output logic [DW-1:0]      wd_s,
    input  logic [NSLV*DW-1:0] rd_s,
    input  logic [NSLV-1:0]    rdy_s
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    bus_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [SW-1:0]     slot_q, slot_d;
    logic [NSLV-1:0]   sel_q, sel_d, we_s_q, we_s_d, onehot;
    logic [AW-3:0]     addr_q, addr_d, err_addr_q, err_addr_d;
    logic [DW-1:0]     wd_q, wd_d, rdata_q, rdata_d;
    logic              ready_q, ready_d, err_q, err_d;
    logic              dec_hit;
    logic [SW-1:0]     dec_slot;

    sys_bus_dec #(
        .NSLV      (NSLV),
        .SW        (SW),
        .SLOT_BASE (SLOT_BASE)
    ) u_dec (
        .nib    (a[AW-3 -: 4]),
        .hit_c  (dec_hit),
        .slot_c (dec_slot)
    );

    assign onehot  = NSLV'(1) << dec_slot;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        sel_d      = sel_q;
        we_s_d     = we_s_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = a;
                    wd_d   = wd;
                    if (dec_hit) begin
                        slot_d  = dec_slot;
                        cnt_d   = '0;
                        sel_d   = onehot;
                        we_s_d  = we ? onehot : '0;
                        state_d = ACCESS;
                    end else begin
                        // Unmapped: addr_s is loading this same cycle, so capture a directly.
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        rdata_d    = '0;
                        err_addr_d = a;
                        state_d    = DONE;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                if (rdy_s[slot_q]) begin
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = (|we_s_q) ? '0 : rd_s[int'(slot_q)*DW +: DW];
                    sel_d   = '0;
                    we_s_d  = '0;
                    state_d = DONE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    err_addr_d = addr_q;
                    sel_d      = '0;
                    we_s_d     = '0;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            slot_q     <= '0;
            sel_q      <= '0;
            we_s_q     <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            sel_q      <= sel_d;
            we_s_q     <= we_s_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign sel_s    = sel_q;
    assign we_s     = we_s_q;
    assign addr_s   = addr_q;
    assign wd_s     = wd_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench for sys_bus_ctrl with a queue of expected completions.
module tb_sys_bus_ctrl;
    import sys_bus_pkg::*;

    localparam int unsigned NSLV = 4;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 15;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req;
    logic [AW-3:0]      a;
    logic               we;
    logic [DW-1:0]      wd;
    logic [DW-1:0]      rdata;
    logic               ready;
    logic               err;
    logic [AW-3:0]      err_addr;
    logic [NSLV-1:0]    sel_s;
    logic [NSLV-1:0]    we_s;
    logic [AW-3:0]      addr_s;
    logic [DW-1:0]      wd_s;
    logic [NSLV*DW-1:0] rd_s;
    logic [NSLV-1:0]    rdy_s;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    sys_bus_ctrl #(
        .NSLV      (NSLV),
        .AW        (AW),
        .DW        (DW),
        .SLOT_BASE (SLOT_BASE_DEF),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a        (a),
        .we       (we),
        .wd       (wd),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .err_addr (err_addr),
        .sel_s    (sel_s),
        .we_s     (we_s),
        .addr_s   (addr_s),
        .wd_s     (wd_s),
        .rd_s     (rd_s),
        .rdy_s    (rdy_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_rd(input int unsigned k, input logic [DW-1:0] v);
        rd_s[k*DW +: DW] = v;
    endtask

    // Drive a request in the current cycle (cycle 0) and queue its expected completion.
    task automatic start(input logic [AW-3:0] addr, input logic w, input logic [DW-1:0] d,
                         input logic [DW-1:0] erd, input logic eerr);
        a   = addr;
        we  = w;
        wd  = d;
        req = 1'b1;
        cyc = 0;
        exp_q.push_back('{erd, eerr});
    endtask

    task automatic check_done(input string tag, input int lat);
        exp_t e;
        chk({tag, ".ready"}, 64'(ready), 64'(1));
        chk({tag, ".lat"}, 64'(cyc), 64'(lat));
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s.queue: got empty want entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".rdata"}, 64'(rdata), 64'(e.rdata));
            chk({tag, ".err"}, 64'(err), 64'(e.err));
        end
    endtask

    task automatic wait_done(input string tag, input int lat, input int maxc);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
        check_done(tag, lat);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ready"}, 64'(ready), 64'(0));
        chk({tag, ".err"}, 64'(err), 64'(0));
        chk({tag, ".rdata"}, 64'(rdata), 64'(0));
        chk({tag, ".err_addr"}, 64'(err_addr), 64'(0));
        chk({tag, ".sel_s"}, 64'(sel_s), 64'(0));
        chk({tag, ".we_s"}, 64'(we_s), 64'(0));
        chk({tag, ".addr_s"}, 64'(addr_s), 64'(0));
        chk({tag, ".wd_s"}, 64'(wd_s), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        a     = '0;
        we    = 1'b0;
        wd    = '0;
        rd_s  = '0;
        rdy_s = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Zero-wait read from data memory
        set_rd(SLOT_MEM, 32'hDEADBEEF);
        rdy_s = 4'b0001;
        start(10'h005, 1'b0, '0, 32'hDEADBEEF, 1'b0);
        step();
        req = 1'b0;
        chk("rd.sel_s", 64'(sel_s), 64'(4'b0001));
        chk("rd.addr_s", 64'(addr_s), 64'(10'h005));
        chk("rd.we_s", 64'(we_s), 64'(0));
        step();
        check_done("rd", 2);
        step();
        chk("rd.pulse", 64'(ready), 64'(0));

        // GPIO write with three wait cycles; stale read data must not leak
        rdy_s = '0;
        set_rd(SLOT_GPIO, 32'hBAD0BAD0);
        start(10'h241, 1'b1, 32'h0000_00A5, '0, 1'b0);
        step();
        req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("wr.we_s%0d", i), 64'(we_s), 64'(4'b0100));
            chk($sformatf("wr.ready%0d", i), 64'(ready), 64'(0));
            if (i == 1) chk("wr.wd_s", 64'(wd_s), 64'(32'hA5));
            if (i == 4) rdy_s = 4'b0100;
            step();
        end
        check_done("wr", 5);
        rdy_s = '0;
        step();

        // Unmapped address
        start(10'h3C0, 1'b0, '0, '0, 1'b1);
        step();
        req = 1'b0;
        chk("unm.sel_s", 64'(sel_s), 64'(0));
        check_done("unm", 1);
        chk("unm.err_addr", 64'(err_addr), 64'(10'h3C0));
        step();

        // Slot 1 never ready; other slots' ready must be ignored
        rdy_s = 4'b1101;
        start(10'h200, 1'b0, '0, '0, 1'b1);
        step();
        req = 1'b0;
        for (int i = 1; i <= int'(TO); i++) begin
            chk($sformatf("to.sel_s%0d", i), 64'(sel_s), 64'(4'b0010));
            step();
        end
        check_done("to", int'(TO) + 1);
        chk("to.err_addr", 64'(err_addr), 64'(10'h200));
        rdy_s = '0;
        step();

        // Ready on the final permitted cycle wins over timeout
        set_rd(SLOT_FACT, 32'h0000_1234);
        start(10'h201, 1'b0, '0, 32'h0000_1234, 1'b0);
        step();
        req = 1'b0;
        for (int i = 1; i <= int'(TO); i++) begin
            if (i == int'(TO)) rdy_s = 4'b0010;
            step();
        end
        check_done("edge", int'(TO) + 1);
        chk("edge.err_addr", 64'(err_addr), 64'(10'h200));
        rdy_s = '0;
        step();

        // Asynchronous reset in the middle of a waiting access
        start(10'h240, 1'b0, '0, '0, 1'b0);
        void'(exp_q.pop_back());
        step();
        req = 1'b0;
        step();
        chk("rst.sel_pre", 64'(sel_s), 64'(4'b0100));
        rst_n = 1'b0;
        #1;
        chk_zero("rst");
        #10;
        rst_n = 1'b1;
        step();

        // Normal write after reset
        rdy_s = 4'b0001;
        start(10'h010, 1'b1, 32'h0000_55AA, '0, 1'b0);
        step();
        req = 1'b0;
        chk("post.we_s", 64'(we_s), 64'(4'b0001));
        step();
        check_done("post", 2);
        step();

        // req held high: second transaction accepted at the IDLE after DONE
        set_rd(SLOT_MEM, 32'hCAFE0001);
        start(10'h007, 1'b0, '0, 32'hCAFE0001, 1'b0);
        exp_q.push_back('{32'hCAFE0001, 1'b0});
        step();
        step();
        check_done("b2b1", 2);
        step();
        chk("b2b.idle_sel", 64'(sel_s), 64'(0));
        step();
        req = 1'b0;
        chk("b2b.sel_s", 64'(sel_s), 64'(4'b0001));
        wait_done("b2b2", 5, 4);
        rdy_s = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
